// File: rtl/bist_sig_checker.sv
// BIST signature checker: sequences a MISR through run/flush/check and compares its
// signature against a golden value. Define BIST_TIMEOUT_EN to build the watchdog.
module bist_sig_checker #(
   parameter int NUM_BITS = 54,
   parameter int CNT_W    = 16
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_start,
   input  logic [CNT_W-1:0]    i_num_vec,
   input  logic [NUM_BITS-1:0] i_golden,
   input  logic [CNT_W-1:0]    i_timeout,
   input  logic                i_res_vld,
   output logic                o_misr_mode,
   output logic                o_misr_done,
   input  logic                i_misr_vld,
   input  logic [NUM_BITS-1:0] i_misr_data,
   output logic                o_busy,
   output logic                o_pass,
   output logic                o_fail,
   output logic                o_timeout,
   output logic [CNT_W-1:0]    o_vec_cnt,
   output logic [NUM_BITS-1:0] o_sig
);

   typedef enum logic [2:0] {IDLE, RUN, FLUSH, CHECK, DONE} state_e;

   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    vecCnt_q, vecCnt_d;
   logic [CNT_W-1:0]    numVec_q, numVec_d;
   logic [NUM_BITS-1:0] golden_q, golden_d;
   logic [NUM_BITS-1:0] sig_q, sig_d;
   logic                pass_q, pass_d;
   logic                fail_q, fail_d;

`ifdef BIST_TIMEOUT_EN
   logic [CNT_W-1:0]    wdog_q, wdog_d;
   logic [CNT_W-1:0]    tmoLim_q, tmoLim_d;
   logic                tmo_q, tmo_d;
   logic [CNT_W-1:0]    wdogInc;
   logic                wdogHit;

   assign wdogInc = (wdog_q == '1) ? wdog_q : wdog_q + CntOne;
   assign wdogHit = (tmoLim_q != '0) && (wdogInc == tmoLim_q);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wdog_q   <= '0;
         tmoLim_q <= '0;
         tmo_q    <= 1'b0;
      end else begin
         wdog_q   <= wdog_d;
         tmoLim_q <= tmoLim_d;
         tmo_q    <= tmo_d;
      end
   end

   assign o_timeout = tmo_q;
`else
   logic unusedTimeout;
   assign unusedTimeout = ^i_timeout;
   assign o_timeout     = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         vecCnt_q <= '0;
         numVec_q <= '0;
         golden_q <= '0;
         sig_q    <= '0;
         pass_q   <= 1'b0;
         fail_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         vecCnt_q <= vecCnt_d;
         numVec_q <= numVec_d;
         golden_q <= golden_d;
         sig_q    <= sig_d;
         pass_q   <= pass_d;
         fail_q   <= fail_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      vecCnt_d = vecCnt_q;
      numVec_d = numVec_q;
      golden_d = golden_q;
      sig_d    = sig_q;
      pass_d   = pass_q;
      fail_d   = fail_q;
`ifdef BIST_TIMEOUT_EN
      wdog_d   = wdog_q;
      tmoLim_d = tmoLim_q;
      tmo_d    = tmo_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (i_start) begin
               vecCnt_d = '0;
               numVec_d = i_num_vec;
               golden_d = i_golden;
               pass_d   = 1'b0;
               fail_d   = 1'b0;
               state_d  = (i_num_vec == '0) ? FLUSH : RUN;
`ifdef BIST_TIMEOUT_EN
               wdog_d   = '0;
               tmoLim_d = i_timeout;
               tmo_d    = 1'b0;
`endif
            end
         end
         RUN: begin
            if (i_res_vld) begin
               // Only beats up to the latched count are accepted; the count also saturates.
               if (vecCnt_q != numVec_q && vecCnt_q != '1) begin
                  vecCnt_d = vecCnt_q + CntOne;
               end
               if (vecCnt_q + CntOne == numVec_q) begin
                  state_d = FLUSH;
               end
`ifdef BIST_TIMEOUT_EN
               wdog_d = '0;
            end else begin
               wdog_d = wdogInc;
               if (wdogHit) begin
                  tmo_d   = 1'b1;
                  state_d = DONE;
               end
`endif
            end
         end
         FLUSH: begin
            state_d = CHECK;
`ifdef BIST_TIMEOUT_EN
            wdog_d  = '0;
`endif
         end
         CHECK: begin
            if (i_misr_vld) begin
               sig_d   = i_misr_data;
               pass_d  = (i_misr_data == golden_q);
               fail_d  = (i_misr_data != golden_q);
               state_d = DONE;
`ifdef BIST_TIMEOUT_EN
            end else begin
               wdog_d = wdogInc;
               if (wdogHit) begin
                  tmo_d   = 1'b1;
                  state_d = DONE;
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign o_busy      = (state_q == RUN) || (state_q == FLUSH) || (state_q == CHECK);
   assign o_misr_mode = (state_q != IDLE);
   assign o_misr_done = (state_q == FLUSH) || (state_q == CHECK);
   assign o_pass      = pass_q;
   assign o_fail      = fail_q;
   assign o_vec_cnt   = vecCnt_q;
   assign o_sig       = sig_q;

endmodule

// File: tb/tb_bist_sig_checker.sv
// Self-checking bench for bist_sig_checker with a one-cycle-response MISR model;
// expected verdicts go through a scoreboard queue.
module tb_bist_sig_checker;

   typedef struct {
      logic        pass;
      logic        fail;
      logic        tmo;
      logic [53:0] sig;
      logic [15:0] cnt;
   } verdict_t;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        start = 1'b0;
   logic [15:0] numVec = '0;
   logic [53:0] golden = '0;
   logic [15:0] timeoutLim = '0;
   logic        resVld = 1'b0;
   logic        misrMode, misrDone;
   logic        misrVld;
   logic [53:0] misrValue = '0;
   logic        busy, pass, fail, timeoutFlag;
   logic [15:0] vecCnt;
   logic [53:0] sig;

   verdict_t    expQ[$];
   int          checkCount = 0;
   int          passCount = 0;

   always #5 clk = ~clk;

   // MISR model: signature valid one cycle after it sees i_done
   always @(posedge clk or negedge rstN) begin
      if (!rstN) misrVld <= 1'b0;
      else       misrVld <= misrDone;
   end

   bist_sig_checker dut (
      .i_clk       (clk),
      .i_rst_n     (rstN),
      .i_start     (start),
      .i_num_vec   (numVec),
      .i_golden    (golden),
      .i_timeout   (timeoutLim),
      .i_res_vld   (resVld),
      .o_misr_mode (misrMode),
      .o_misr_done (misrDone),
      .i_misr_vld  (misrVld),
      .i_misr_data (misrValue),
      .o_busy      (busy),
      .o_pass      (pass),
      .o_fail      (fail),
      .o_timeout   (timeoutFlag),
      .o_vec_cnt   (vecCnt),
      .o_sig       (sig)
   );

   task automatic startRun(input logic [15:0] n, input logic [53:0] g, input logic [15:0] t);
      @(negedge clk);
      start = 1'b1; numVec = n; golden = g; timeoutLim = t;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic sendBeats(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         resVld = 1'b1;
      end
      @(negedge clk);
      resVld = 1'b0;
   endtask

   task automatic waitIdle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      #2;
      checkCount++;
      if ({busy, misrMode, misrDone, pass, fail, timeoutFlag} !== 6'b0)
         $display("[TB] FAIL reset_flags: got %b expected 000000", {busy, misrMode, misrDone, pass, fail, timeoutFlag});
      else passCount++;
      checkCount++;
      if (vecCnt !== 16'd0 || sig !== 54'd0)
         $display("[TB] FAIL reset_data: got cnt=%0d sig=%h expected 0/0", vecCnt, sig);
      else passCount++;
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);
      checkCount++;
      if (busy !== 1'b0 || misrMode !== 1'b0)
         $display("[TB] FAIL reset_idle: got busy=%b mode=%b expected 0/0", busy, misrMode);
      else passCount++;
   endtask

   task automatic test_normal_pass;
      verdict_t e;
      misrValue = 54'h0A5;
      startRun(16'd4, 54'h0A5, 16'd100);
      checkCount++;
      if (busy !== 1'b1 || misrMode !== 1'b1)
         $display("[TB] FAIL pass_run: got busy=%b mode=%b expected 1/1", busy, misrMode);
      else passCount++;
      expQ.push_back('{pass: 1'b1, fail: 1'b0, tmo: 1'b0, sig: 54'h0A5, cnt: 16'd4});
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         resVld = 1'b1;
      end
      @(negedge clk);
      resVld = 1'b0;
      checkCount++;
      if (misrDone !== 1'b1 || vecCnt !== 16'd4)
         $display("[TB] FAIL pass_flush: got done=%b cnt=%0d expected 1/4", misrDone, vecCnt);
      else passCount++;
      @(negedge clk);
      checkCount++;
      if (busy !== 1'b1 || pass !== 1'b0)
         $display("[TB] FAIL pass_early: got busy=%b pass=%b expected 1/0", busy, pass);
      else passCount++;
      @(negedge clk);
      e = expQ.pop_front();
      checkCount++;
      if ({pass, fail, timeoutFlag} !== {e.pass, e.fail, e.tmo} || busy !== 1'b0)
         $display("[TB] FAIL pass_verdict: got pft=%b busy=%b expected %b/0", {pass, fail, timeoutFlag}, busy, {e.pass, e.fail, e.tmo});
      else passCount++;
      checkCount++;
      if (vecCnt !== e.cnt || sig !== e.sig)
         $display("[TB] FAIL pass_data: got cnt=%0d sig=%h expected %0d/%h", vecCnt, sig, e.cnt, e.sig);
      else passCount++;
   endtask

   task automatic test_mismatch;
      verdict_t e;
      bit ok;
      misrValue = 54'h0A4;
      startRun(16'd3, 54'h0A5, 16'd100);
      expQ.push_back('{pass: 1'b0, fail: 1'b1, tmo: 1'b0, sig: 54'h0A4, cnt: 16'd3});
      sendBeats(3);
      waitIdle(20, ok);
      checkCount++;
      if (!ok) $display("[TB] FAIL mismatch_wait: got busy=%b expected 0 within budget", busy);
      else passCount++;
      e = expQ.pop_front();
      checkCount++;
      if ({pass, fail, timeoutFlag} !== {e.pass, e.fail, e.tmo})
         $display("[TB] FAIL mismatch_verdict: got pft=%b expected %b", {pass, fail, timeoutFlag}, {e.pass, e.fail, e.tmo});
      else passCount++;
      checkCount++;
      if (sig !== e.sig || vecCnt !== e.cnt)
         $display("[TB] FAIL mismatch_data: got sig=%h cnt=%0d expected %h/%0d", sig, vecCnt, e.sig, e.cnt);
      else passCount++;
   endtask

   task automatic test_zero_vectors;
      verdict_t e;
      misrValue = 54'h3C3C;
      expQ.push_back('{pass: 1'b1, fail: 1'b0, tmo: 1'b0, sig: 54'h3C3C, cnt: 16'd0});
      @(negedge clk);
      start = 1'b1; numVec = 16'd0; golden = 54'h3C3C; timeoutLim = 16'd100;
      @(negedge clk);
      start = 1'b0;
      checkCount++;
      if (misrDone !== 1'b1 || busy !== 1'b1 || pass !== 1'b0)
         $display("[TB] FAIL zero_flush: got done=%b busy=%b pass=%b expected 1/1/0", misrDone, busy, pass);
      else passCount++;
      @(negedge clk);
      checkCount++;
      if (misrDone !== 1'b1)
         $display("[TB] FAIL zero_check: got done=%b expected 1", misrDone);
      else passCount++;
      @(negedge clk);
      e = expQ.pop_front();
      checkCount++;
      if (misrDone !== 1'b0 || {pass, fail, timeoutFlag} !== {e.pass, e.fail, e.tmo} || vecCnt !== e.cnt)
         $display("[TB] FAIL zero_verdict: got done=%b pft=%b cnt=%0d expected 0/%b/%0d", misrDone, {pass, fail, timeoutFlag}, vecCnt, {e.pass, e.fail, e.tmo}, e.cnt);
      else passCount++;
   endtask

   task automatic test_back_to_back;
      verdict_t e;
      bit ok;
      misrValue = 54'h0A5;
      startRun(16'd2, 54'h0A5, 16'd100);
      expQ.push_back('{pass: 1'b1, fail: 1'b0, tmo: 1'b0, sig: 54'h0A5, cnt: 16'd2});
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         resVld = 1'b1;
         start  = (i == 0);
         if (i == 0) begin
            numVec = 16'd7; golden = 54'h123;
         end
      end
      @(negedge clk);
      resVld = 1'b0;
      start  = 1'b0;
      waitIdle(20, ok);
      checkCount++;
      if (!ok) $display("[TB] FAIL b2b_wait: got busy=%b expected 0 within budget", busy);
      else passCount++;
      e = expQ.pop_front();
      checkCount++;
      if ({pass, fail, timeoutFlag} !== {e.pass, e.fail, e.tmo} || vecCnt !== e.cnt)
         $display("[TB] FAIL b2b_verdict: got pft=%b cnt=%0d expected %b/%0d", {pass, fail, timeoutFlag}, vecCnt, {e.pass, e.fail, e.tmo}, e.cnt);
      else passCount++;
      repeat (3) @(negedge clk);
      checkCount++;
      if (busy !== 1'b0 || pass !== 1'b1 || vecCnt !== 16'd2)
         $display("[TB] FAIL b2b_single: got busy=%b pass=%b cnt=%0d expected 0/1/2", busy, pass, vecCnt);
      else passCount++;
   endtask

   task automatic test_timeout;
      verdict_t e;
      misrValue = 54'h0A5;
      startRun(16'd3, 54'h0A5, 16'd8);
`ifdef BIST_TIMEOUT_EN
      expQ.push_back('{pass: 1'b0, fail: 1'b0, tmo: 1'b1, sig: 54'h0, cnt: 16'd1});
      sendBeats(1);
      repeat (7) @(negedge clk);
      checkCount++;
      if (busy !== 1'b1 || timeoutFlag !== 1'b0)
         $display("[TB] FAIL tmo_early: got busy=%b tmo=%b expected 1/0", busy, timeoutFlag);
      else passCount++;
      @(negedge clk);
      e = expQ.pop_front();
      checkCount++;
      if ({pass, fail, timeoutFlag} !== {e.pass, e.fail, e.tmo} || busy !== 1'b0 || vecCnt !== e.cnt)
         $display("[TB] FAIL tmo_verdict: got pft=%b busy=%b cnt=%0d expected %b/0/%0d", {pass, fail, timeoutFlag}, busy, vecCnt, {e.pass, e.fail, e.tmo}, e.cnt);
      else passCount++;
`else
      begin
         bit ok;
         expQ.push_back('{pass: 1'b1, fail: 1'b0, tmo: 1'b0, sig: 54'h0A5, cnt: 16'd3});
         sendBeats(1);
         repeat (12) @(negedge clk);
         checkCount++;
         if (busy !== 1'b1 || timeoutFlag !== 1'b0 || misrDone !== 1'b0 || vecCnt !== 16'd1)
            $display("[TB] FAIL tmo_stays_run: got busy=%b tmo=%b done=%b cnt=%0d expected 1/0/0/1", busy, timeoutFlag, misrDone, vecCnt);
         else passCount++;
         sendBeats(2);
         waitIdle(20, ok);
         checkCount++;
         if (!ok) $display("[TB] FAIL tmo_wait: got busy=%b expected 0 within budget", busy);
         else passCount++;
         e = expQ.pop_front();
         checkCount++;
         if ({pass, fail, timeoutFlag} !== {e.pass, e.fail, e.tmo} || vecCnt !== e.cnt)
            $display("[TB] FAIL tmo_verdict: got pft=%b cnt=%0d expected %b/%0d", {pass, fail, timeoutFlag}, vecCnt, {e.pass, e.fail, e.tmo}, e.cnt);
         else passCount++;
      end
`endif
   endtask

   task automatic test_reset_mid_check;
      misrValue = 54'h0A5;
      startRun(16'd1, 54'h0A5, 16'd100);
      sendBeats(1);
      @(negedge clk);
      checkCount++;
      if (misrDone !== 1'b1 || busy !== 1'b1)
         $display("[TB] FAIL rst_in_check: got done=%b busy=%b expected 1/1", misrDone, busy);
      else passCount++;
      rstN = 1'b0;
      #1;
      checkCount++;
      if ({busy, misrMode, misrDone, pass, fail, timeoutFlag} !== 6'b0 || vecCnt !== 16'd0 || sig !== 54'd0)
         $display("[TB] FAIL rst_async: got flags=%b cnt=%0d sig=%h expected 0/0/0", {busy, misrMode, misrDone, pass, fail, timeoutFlag}, vecCnt, sig);
      else passCount++;
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);
      checkCount++;
      if (busy !== 1'b0 || misrMode !== 1'b0 || pass !== 1'b0 || fail !== 1'b0)
         $display("[TB] FAIL rst_idle: got busy=%b mode=%b pass=%b fail=%b expected 0/0/0/0", busy, misrMode, pass, fail);
      else passCount++;
   endtask

   initial begin
      $display("[TB] starting bist_sig_checker bench");
      test_reset;
      test_normal_pass;
      test_mismatch;
      test_zero_vectors;
      test_back_to_back;
      test_timeout;
      test_reset_mid_check;
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
